down_timer: RTL
===============

// Module: down_timer
// PURPOSE
//   Loadable, pausable down-counter with terminal-count pulse; the counting-down
//   counterpart of the lab up-counter. Counts a programmed value down to zero
//   at a prescaled rate, then stops (one-shot) or reloads (periodic). Used as
//   a delay/timeout and periodic-tick source for lab benches and control FSMs.
// PARAMETERS
//   WIDTH  4  counter / load value width in bits
//   DIV    1  prescale: one decrement per DIV clk cycles while running (DIV >= 1)
// PORTS
//   clk          in   1      clock; all state changes on posedge clk
//   rst          in   1      reset; synchronous, active-high
//   load         in   1      load load_val into counter and reload register
//   load_val     in   WIDTH  value captured on load
//   start        in   1      begin / resume / re-arm counting
//   stop         in   1      pause counting (RUN -> PAUSE)
//   auto_reload  in   1      1 = periodic, 0 = one-shot; sampled at each zero crossing
//   ctr          out  WIDTH  current count (registered)
//   busy         out  1      1 while state == RUN
//   tc           out  1      one-cycle pulse, high in the first cycle ctr reaches 0 / reloads
//   done         out  1      sticky: one-shot expiry; cleared by load, start or rst
// BEHAVIOUR
//   - Reset (rst=1 at edge): ctr=0, reload_reg=0, prescaler=0, state=IDLE,
//     busy=0, tc=0, done=0. rst overrides every other input.
//   - Priority per edge: rst > load > stop > start > prescaler tick.
//   - States IDLE, RUN, PAUSE, DONE:
//     IDLE : start & ctr!=0 -> RUN; start & ctr==0 ignored (stay IDLE).
//     RUN  : stop -> PAUSE (ctr, prescaler hold); tick decrements ctr by 1.
//     PAUSE: start -> RUN, prescaler resumes from held value (no lost phase).
//     DONE : start & reload_reg!=0 -> ctr<=reload_reg, done<=0, RUN;
//            start & reload_reg==0 -> ignored.
//   - load (any state): ctr<=load_val, reload_reg<=load_val, prescaler<=0,
//     done<=0, state<=IDLE. load & start same edge: load wins, start dropped.
//   - Prescaler: 0..DIV-1, advances only in RUN; tick when value == DIV-1
//     (then wraps to 0). DIV=1 -> tick every RUN cycle.
//   - Zero crossing (RUN, tick, ctr==1): tc<=1 for exactly one cycle.
//     auto_reload=1 & reload_reg!=0: ctr<=reload_reg, stay RUN (no dead cycle).
//     else: ctr<=0, state<=DONE, done<=1, busy<=0.
//   - stop at the crossing edge: stop wins; no decrement, no tc.
//   - Latency: start at edge k -> first decrement at edge k+DIV; tc asserted
//     after edge k+N*DIV for load value N. Periodic period = N*DIV cycles.
//   - ctr never underflows/wraps below 0; decrement is modulo-free by construction.
//   - rst mid-count: all state cleared next edge, tc/done never glitch high.
// STRUCTURE
//   - Shared package: state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3)
//     as localparams/typedef, reused by benches for state checks.
//   - One sub-module: tick_gen (prescaler; inputs clk, rst, en, clr; output tick).
//   - Top holds FSM, ctr, reload_reg, output registers; all outputs registered.
// TESTING
//   1. rst=1 two cycles, any inputs -> ctr=0, busy=0, tc=0, done=0.
//   2. DIV=1, load 5, start, auto_reload=0 -> ctr 5,4,3,2,1,0 one per cycle;
//      tc=1 one cycle when ctr=0; done=1 held; busy=0; ctr stays 0.
//   3. DIV=1, load 3, auto_reload=1, start -> ctr 3,2,1,3,2,1,...; tc every 3
//      cycles; done never set; busy stays 1.
//   4. DIV=4, load 2, start, stop after 6 cycles hold 10 cycles, start ->
//      ctr=1 frozen during pause; tc 2 cycles after resume (8 RUN cycles total).
//   5. load and start same edge, then start with load_val=0 -> state IDLE,
//      no counting; in DONE with reload_reg=7, start -> ctr=7, RUN, done=0.
//   6. rst asserted at ctr=1 on tick edge -> ctr=0, tc=0, done=0 next cycle.

Source files
------------

// File: rtl/down_timer_pkg.sv
// down_timer_pkg
//   Shared definitions for the down_timer block: FSM state encoding and the
//   default parameter values. Benches import this package to compare
//   observed state against the named encodings.
package down_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DIV   = 1;

endpackage : down_timer_pkg

// File: rtl/down_timer_if.sv
// down_timer_if
//   Control/status bundle of the down_timer.
//   master : drives load, load_val, start, stop, auto_reload; observes status
//   slave  : the timer itself; observes control, drives ctr, busy, tc, done
interface down_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] ctr;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output load, load_val, start, stop, auto_reload,
        input  ctr, busy, tc, done
    );

    modport slave (
        input  load, load_val, start, stop, auto_reload,
        output ctr, busy, tc, done
    );
endinterface : down_timer_if

// File: rtl/down_timer_tick_gen.sv
// tick_gen
//   Prescaler for the down_timer. Counts 0..DIV-1 while en is high and
//   flags the wrap cycle with tick; holds its value while en is low so a
//   paused timer resumes with no lost phase.
//   clk  : clock
//   rst  : synchronous active-high reset (count -> 0)
//   en   : advance the prescaler this cycle
//   clr  : force the count back to 0
//   tick : high in the cycle the count is DIV-1 and en is high
module tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = en && (cnt_q == LAST);
endmodule : tick_gen

// File: rtl/down_timer.sv
// down_timer
//   Loadable, pausable down-counter with prescaler, terminal-count pulse and
//   one-shot / periodic modes.
//   clk : clock, all state changes on posedge
//   rst : synchronous active-high reset
//   bus : down_timer_if.slave
//         load/load_val  capture load_val into ctr and reload register
//         start / stop   run-resume-rearm / pause
//         auto_reload    1 = periodic, 0 = one-shot (sampled at zero crossing)
//         ctr            current count
//         busy           high while in RUN
//         tc             one-cycle pulse at zero crossing / reload
//         done           sticky one-shot expiry flag
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV   = DEF_DIV
) (
    input  logic         clk,
    input  logic         rst,
    down_timer_if.slave  bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] ctr_q, ctr_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             tc_q, tc_d;
    logic             busy_q;
    logic             run_en;
    logic             tick;

    // Prescaler only advances on RUN cycles not overridden by load or stop,
    // so a stop on the crossing edge also freezes the prescaler phase.
    assign run_en = (state_q == RUN) && !bus.load && !bus.stop;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .clr  (bus.load),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        reload_d = reload_q;
        done_d   = done_q;
        tc_d     = 1'b0;

        if (bus.load) begin
            ctr_d    = bus.load_val;
            reload_d = bus.load_val;
            done_d   = 1'b0;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.stop && bus.start && ctr_q != '0) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        // ctr==0 cannot occur in RUN; treating it as a
                        // crossing keeps the counter from ever wrapping.
                        if (ctr_q <= WIDTH'(1)) begin
                            tc_d = 1'b1;
                            if (bus.auto_reload && reload_q != '0) begin
                                ctr_d = reload_q;
                            end else begin
                                ctr_d   = '0;
                                done_d  = 1'b1;
                                state_d = DONE;
                            end
                        end else begin
                            ctr_d = ctr_q - 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (!bus.stop && bus.start) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (!bus.stop && bus.start && reload_q != '0) begin
                        ctr_d   = reload_q;
                        done_d  = 1'b0;
                        state_d = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ctr_q    <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            tc_q     <= tc_d;
            busy_q   <= (state_d == RUN);
        end
    end

    assign bus.ctr  = ctr_q;
    assign bus.busy = busy_q;
    assign bus.tc   = tc_q;
    assign bus.done = done_q;
endmodule : down_timer
